// File: rtl/uart_cmd_parser_if.sv
// Byte handshake between the UART rx/tx pair and the command parser.
// master = UART side (delivers rx bytes, reports tx completion); slave = parser.
interface uart_cmd_parser_if;
  logic       rx_byte_valid;
  logic [7:0] rx_byte_data;
  logic       tx_done;
  logic       tx_byte_valid;
  logic [7:0] tx_byte_data;

  modport master (
    output rx_byte_valid,
    output rx_byte_data,
    output tx_done,
    input  tx_byte_valid,
    input  tx_byte_data
  );

  modport slave (
    input  rx_byte_valid,
    input  rx_byte_data,
    input  tx_done,
    output tx_byte_valid,
    output tx_byte_data
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// ASCII line-command parser: "L<hex>\r" sets the LED register, "R\r" reads it back.
// Define CMD_ECHO_EN to echo every byte received outside a reply.
//
// state     | meaning
// IDLE      | waiting for a command letter; bare CR/LF ignored
// GOT_L     | 'L' seen, expecting one hex digit
// GOT_ARG   | digit latched, expecting CR
// GOT_R     | 'R' seen, expecting CR
// ERR_FLUSH | bad input, discarding until CR then error reply
// RESP      | sending reply bytes, one per tx_done
module uart_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  uart_cmd_parser_if.slave bus,
  output logic [3:0]       led_out,
  output logic             cmd_error,
  output logic             rx_overrun
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, GOT_L, GOT_ARG, GOT_R, ERR_FLUSH, RESP} state_t;
  typedef enum logic [1:0] {RK_OK, RK_READ, RK_ERR} resp_t;

  state_t        state, state_nxt;
  resp_t         kind, kind_nxt, trig_kind;
  logic [TW-1:0] to_cnt, cnt_nxt;
  logic [3:0]    arg, arg_nxt, led_nxt;
  logic [1:0]    idx, idx_nxt;
  logic          pend, pend_nxt;
  logic          tx_valid, tx_valid_nxt;
  logic [7:0]    tx_data, tx_data_nxt;
  logic          err_nxt, ovr_nxt, trig;
  logic          in_flight, echo_go;

  logic [7:0] rx_up;
  logic       is_cr, is_lf, is_hex;
  logic [3:0] hex_val;

  function automatic logic [7:0] hex_char(input logic [3:0] v);
    return (v < 4'd10) ? {4'h3, v} : {4'h4, v - 4'd9};
  endfunction

  function automatic logic [1:0] last_idx(input resp_t k);
    return (k == RK_READ) ? 2'd3 : 2'd2;
  endfunction

  function automatic logic [7:0] resp_byte(input resp_t k, input logic [1:0] i,
                                           input logic [3:0] v);
    logic [7:0] b;
    b = 8'h00;
    if (k == RK_READ) begin
      case (i)
        2'd0:    b = "L";
        2'd1:    b = hex_char(v);
        2'd2:    b = 8'h0D;
        default: b = 8'h0A;
      endcase
    end else begin
      case (i)
        2'd0:    b = (k == RK_ERR) ? "E" : "K";
        2'd1:    b = 8'h0D;
        2'd2:    b = 8'h0A;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  always_comb begin
    rx_up = bus.rx_byte_data;
    if (bus.rx_byte_data >= "a" && bus.rx_byte_data <= "z")
      rx_up = bus.rx_byte_data - 8'h20;
    is_cr   = (rx_up == 8'h0D);
    is_lf   = (rx_up == 8'h0A);
    is_hex  = (rx_up >= "0" && rx_up <= "9") || (rx_up >= "A" && rx_up <= "F");
    // low nibble of 'A'..'F' is 1..6, so +9 maps it onto 10..15
    hex_val = rx_up[3:0] + ((rx_up >= "A") ? 4'd9 : 4'd0);
  end

`ifdef CMD_ECHO_EN
  logic tx_busy;

  always_ff @(posedge CLK100MHZ) begin
    if (reset)             tx_busy <= 1'b0;
    else if (tx_valid_nxt) tx_busy <= 1'b1;
    else if (bus.tx_done)  tx_busy <= 1'b0;
  end

  // a completion arriving this cycle frees the transmitter for the next strobe
  assign in_flight = tx_busy && !bus.tx_done;
  assign echo_go   = bus.rx_byte_valid && (state != RESP) && !in_flight;
`else
  assign in_flight = 1'b0;
  assign echo_go   = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    kind_nxt     = kind;
    cnt_nxt      = to_cnt;
    arg_nxt      = arg;
    idx_nxt      = idx;
    pend_nxt     = pend;
    led_nxt      = led_out;
    tx_valid_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    err_nxt      = 1'b0;
    ovr_nxt      = 1'b0;
    trig         = 1'b0;
    trig_kind    = RK_ERR;

    case (state)
      IDLE: begin
        if (bus.rx_byte_valid) begin
          if (rx_up == "L")         state_nxt = GOT_L;
          else if (rx_up == "R")    state_nxt = GOT_R;
          else if (!(is_cr || is_lf)) state_nxt = ERR_FLUSH;
        end
      end
      GOT_L: begin
        if (bus.rx_byte_valid) begin
          if (is_hex) begin
            state_nxt = GOT_ARG;
            arg_nxt   = hex_val;
          end else if (is_cr) begin
            trig = 1'b1;
          end else begin
            state_nxt = ERR_FLUSH;
          end
        end
      end
      GOT_ARG: begin
        if (bus.rx_byte_valid) begin
          if (is_cr) begin
            trig      = 1'b1;
            trig_kind = RK_OK;
            led_nxt   = arg;
          end else begin
            state_nxt = ERR_FLUSH;
          end
        end
      end
      GOT_R: begin
        if (bus.rx_byte_valid) begin
          if (is_cr) begin
            trig      = 1'b1;
            trig_kind = RK_READ;
          end else begin
            state_nxt = ERR_FLUSH;
          end
        end
      end
      ERR_FLUSH: begin
        if (bus.rx_byte_valid && is_cr) trig = 1'b1;
      end
      RESP: begin
        if (bus.rx_byte_valid) ovr_nxt = 1'b1;
        if (bus.tx_done) begin
          if (pend) begin
            pend_nxt     = 1'b0;
            tx_valid_nxt = 1'b1;
            tx_data_nxt  = resp_byte(kind, idx, led_out);
          end else if (idx == last_idx(kind)) begin
            state_nxt = IDLE;
          end else begin
            idx_nxt      = idx + 2'd1;
            tx_valid_nxt = 1'b1;
            tx_data_nxt  = resp_byte(kind, idx + 2'd1, led_out);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // a byte arriving on the expiry cycle is parsed above and restarts the count
    if (state inside {GOT_L, GOT_ARG, GOT_R, ERR_FLUSH}) begin
      if (bus.rx_byte_valid) begin
        cnt_nxt = '0;
      end else if (to_cnt == TO_LAST) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = to_cnt + 1'b1;
      end
    end else begin
      cnt_nxt = '0;
    end

    if (echo_go) begin
      tx_valid_nxt = 1'b1;
      tx_data_nxt  = bus.rx_byte_data;
    end

    if (trig) begin
      state_nxt = RESP;
      kind_nxt  = trig_kind;
      idx_nxt   = 2'd0;
      err_nxt   = (trig_kind == RK_ERR);
      if (echo_go || in_flight) begin
        pend_nxt = 1'b1;
      end else begin
        pend_nxt     = 1'b0;
        tx_valid_nxt = 1'b1;
        tx_data_nxt  = resp_byte(trig_kind, 2'd0, led_out);
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state      <= IDLE;
      kind       <= RK_OK;
      to_cnt     <= '0;
      arg        <= 4'h0;
      idx        <= 2'd0;
      pend       <= 1'b0;
      led_out    <= 4'h0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      cmd_error  <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      state      <= state_nxt;
      kind       <= kind_nxt;
      to_cnt     <= cnt_nxt;
      arg        <= arg_nxt;
      idx        <= idx_nxt;
      pend       <= pend_nxt;
      led_out    <= led_nxt;
      tx_valid   <= tx_valid_nxt;
      tx_data    <= tx_data_nxt;
      cmd_error  <= err_nxt;
      rx_overrun <= ovr_nxt;
    end
  end

  assign bus.tx_byte_valid = tx_valid;
  assign bus.tx_byte_data  = tx_data;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: expected reply bytes queued with each command,
// compared against bytes captured by a transmitter model that answers each strobe after TX_DLY cycles.
`timescale 1ns/1ps
module tb_uart_cmd_parser;
  localparam int TO     = 50;
  localparam int TX_DLY = 10;

  logic       CLK100MHZ = 1'b0;
  logic       reset     = 1'b1;
  logic [3:0] led_out;
  logic       cmd_error;
  logic       rx_overrun;

  uart_cmd_parser_if bus();

  uart_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .bus       (bus),
    .led_out   (led_out),
    .cmd_error (cmd_error),
    .rx_overrun(rx_overrun)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int cyc = 0;
  always @(posedge CLK100MHZ) cyc <= cyc + 1;

  int tests  = 0;
  int failed = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         gap_q[$];
  int tx_wait   = 0;
  int last_done = -1000;
  int proto_err = 0;
  int err_cnt   = 0;
  int ovr_cnt   = 0;

  // transmitter model: completes each byte TX_DLY cycles after its strobe
  always @(negedge CLK100MHZ) begin
    bus.tx_done = 1'b0;
    if (tx_wait > 0) begin
      tx_wait--;
      if (tx_wait == 0) begin
        bus.tx_done = 1'b1;
        last_done   = cyc;
      end
    end
    if (bus.tx_byte_valid === 1'b1) begin
      if (tx_wait > 0) proto_err++;
      obs_q.push_back(bus.tx_byte_data);
      gap_q.push_back(cyc - last_done);
      tx_wait = TX_DLY;
    end
    if (cmd_error === 1'b1)  err_cnt++;
    if (rx_overrun === 1'b1) ovr_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK100MHZ);
    bus.rx_byte_valid = 1'b1;
    bus.rx_byte_data  = b;
    @(negedge CLK100MHZ);
    bus.rx_byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK100MHZ);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(3);
    tests++; if (bus.tx_byte_valid !== 1'b0) begin failed++; $display("FAIL reset_tx_valid: got %b want 0", bus.tx_byte_valid); end
    tests++; if (bus.tx_byte_data !== 8'h00) begin failed++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_byte_data); end
    tests++; if (led_out !== 4'h0) begin failed++; $display("FAIL reset_led: got %h want 0", led_out); end
    tests++; if (cmd_error !== 1'b0) begin failed++; $display("FAIL reset_cmd_error: got %b want 0", cmd_error); end
    tests++; if (rx_overrun !== 1'b0) begin failed++; $display("FAIL reset_overrun: got %b want 0", rx_overrun); end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_led_write;
    int e0;
    logic [7:0] e, o;
    int g;
    e0 = err_cnt;
    send_byte("L"); send_byte("A");
    exp_q.push_back(8'h4B); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    send_byte(8'h0D);
    tests++; if (led_out !== 4'hA) begin failed++; $display("FAIL write_led_at_cr1: got %h want a", led_out); end
    tests++; if (bus.tx_byte_valid !== 1'b1) begin failed++; $display("FAIL write_strobe_at_cr1: got %b want 1", bus.tx_byte_valid); end
    idle(60);
    tests++; if (obs_q.size() != exp_q.size()) begin failed++; $display("FAIL write_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = 8'h00; g = -1;
      if (obs_q.size() > 0) begin o = obs_q.pop_front(); g = gap_q.pop_front(); end
      tests++; if (o !== e) begin failed++; $display("FAIL write_byte%0d: got %h want %h", k, o, e); end
      if (k > 0) begin tests++; if (g != 1) begin failed++; $display("FAIL write_gap%0d: got %0d want 1", k, g); end end
    end
    tests++; if (err_cnt != e0) begin failed++; $display("FAIL write_no_error: got %0d pulses want 0", err_cnt - e0); end
    obs_q.delete(); gap_q.delete();
  endtask

  task automatic test_read;
    logic [7:0] e, o;
    send_byte("r");
    exp_q.push_back(8'h4C); exp_q.push_back(8'h41); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    send_byte(8'h0D);
    idle(60);
    tests++; if (obs_q.size() != exp_q.size()) begin failed++; $display("FAIL read_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'h00;
      tests++; if (o !== e) begin failed++; $display("FAIL read_byte%0d: got %h want %h", k, o, e); end
    end
    tests++; if (led_out !== 4'hA) begin failed++; $display("FAIL read_led_kept: got %h want a", led_out); end
    obs_q.delete(); gap_q.delete();
  endtask

  task automatic test_case_hex;
    logic [7:0] e, o;
    send_byte("l"); send_byte("b");
    exp_q.push_back(8'h4B); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    send_byte(8'h0D);
    tests++; if (led_out !== 4'hB) begin failed++; $display("FAIL lower_led: got %h want b", led_out); end
    idle(60);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'h00;
      tests++; if (o !== e) begin failed++; $display("FAIL lower_byte%0d: got %h want %h", k, o, e); end
    end
    obs_q.delete(); gap_q.delete();
  endtask

  task automatic test_error;
    int e0;
    logic [7:0] e, o;
    send_byte(8'h0D); send_byte(8'h0A);
    idle(5);
    tests++; if (obs_q.size() != 0) begin failed++; $display("FAIL idle_crlf_silent: got %0d bytes want 0", obs_q.size()); end
    e0 = err_cnt;
    send_byte("L"); send_byte("G"); send_byte("x");
    exp_q.push_back(8'h45); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    send_byte(8'h0D);
    tests++; if (cmd_error !== 1'b1) begin failed++; $display("FAIL err_pulse_at_cr1: got %b want 1", cmd_error); end
    idle(60);
    tests++; if (err_cnt - e0 != 1) begin failed++; $display("FAIL err_pulse_count: got %0d want 1", err_cnt - e0); end
    tests++; if (led_out !== 4'hB) begin failed++; $display("FAIL err_led_kept: got %h want b", led_out); end
    send_byte("L");
    exp_q.push_back(8'h45); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    send_byte(8'h0D);
    tests++; if (cmd_error !== 1'b1) begin failed++; $display("FAIL l_cr_err_pulse: got %b want 1", cmd_error); end
    idle(60);
    tests++; if (obs_q.size() != exp_q.size()) begin failed++; $display("FAIL err_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'h00;
      tests++; if (o !== e) begin failed++; $display("FAIL err_byte%0d: got %h want %h", k, o, e); end
    end
    obs_q.delete(); gap_q.delete();
  endtask

  task automatic test_timeout;
    logic [7:0] e, o;
    send_byte("L"); send_byte("3");
    idle(60);
    send_byte(8'h0D);
    tests++; if (bus.tx_byte_valid !== 1'b0) begin failed++; $display("FAIL timeout_no_strobe: got %b want 0", bus.tx_byte_valid); end
    idle(30);
    tests++; if (obs_q.size() != 0) begin failed++; $display("FAIL timeout_silent: got %0d bytes want 0", obs_q.size()); end
    tests++; if (led_out !== 4'hB) begin failed++; $display("FAIL timeout_led_kept: got %h want b", led_out); end
    send_byte("L"); send_byte("3");
    exp_q.push_back(8'h4B); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    send_byte(8'h0D);
    tests++; if (led_out !== 4'h3) begin failed++; $display("FAIL timeout_then_set: got %h want 3", led_out); end
    idle(60);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'h00;
      tests++; if (o !== e) begin failed++; $display("FAIL timeout_byte%0d: got %h want %h", k, o, e); end
    end
    obs_q.delete(); gap_q.delete();
  endtask

  task automatic test_overrun;
    int o0;
    bit hit;
    logic [7:0] e, o;
    o0 = ovr_cnt;
    send_byte("R");
    exp_q.push_back(8'h4C); exp_q.push_back(8'h33); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    send_byte(8'h0D);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(posedge CLK100MHZ); #2;
      if (tx_wait == 1) hit = 1'b1;
    end
    tests++;
    if (!hit) begin
      failed++; $display("FAIL ovr_wait: got no pending tx_done want one within 40 cycles");
    end else begin
      @(negedge CLK100MHZ);
      bus.rx_byte_valid = 1'b1;
      bus.rx_byte_data  = "Z";
      @(negedge CLK100MHZ);
      bus.rx_byte_valid = 1'b0;
      tests++; if (rx_overrun !== 1'b1) begin failed++; $display("FAIL ovr_pulse: got %b want 1", rx_overrun); end
      tests++; if (bus.tx_byte_valid !== 1'b1) begin failed++; $display("FAIL ovr_next_strobe: got %b want 1", bus.tx_byte_valid); end
    end
    idle(60);
    tests++; if (ovr_cnt - o0 != 1) begin failed++; $display("FAIL ovr_count: got %0d want 1", ovr_cnt - o0); end
    tests++; if (obs_q.size() != exp_q.size()) begin failed++; $display("FAIL ovr_reply_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'h00;
      tests++; if (o !== e) begin failed++; $display("FAIL ovr_byte%0d: got %h want %h", k, o, e); end
    end
    obs_q.delete(); gap_q.delete();
  endtask

  task automatic test_reset_mid;
    logic [7:0] e, o;
    send_byte("R");
    exp_q.push_back(8'h4C);
    send_byte(8'h0D);
    tests++; if (bus.tx_byte_valid !== 1'b1) begin failed++; $display("FAIL rmid_first_strobe: got %b want 1", bus.tx_byte_valid); end
    reset = 1'b1;
    @(negedge CLK100MHZ);
    tests++; if (bus.tx_byte_valid !== 1'b0) begin failed++; $display("FAIL rmid_tx_valid: got %b want 0", bus.tx_byte_valid); end
    tests++; if (bus.tx_byte_data !== 8'h00) begin failed++; $display("FAIL rmid_tx_data: got %h want 00", bus.tx_byte_data); end
    tests++; if (led_out !== 4'h0) begin failed++; $display("FAIL rmid_led: got %h want 0", led_out); end
    tests++; if ({cmd_error, rx_overrun} !== 2'b00) begin failed++; $display("FAIL rmid_pulses: got %b want 00", {cmd_error, rx_overrun}); end
    @(negedge CLK100MHZ);
    reset = 1'b0;
    idle(40);
    tests++; if (obs_q.size() != exp_q.size()) begin failed++; $display("FAIL rmid_abandon: got %0d bytes want %0d", obs_q.size(), exp_q.size()); end
    send_byte("L"); send_byte("5");
    exp_q.push_back(8'h4B); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    send_byte(8'h0D);
    tests++; if (led_out !== 4'h5) begin failed++; $display("FAIL rmid_led_set: got %h want 5", led_out); end
    idle(60);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'h00;
      tests++; if (o !== e) begin failed++; $display("FAIL rmid_byte%0d: got %h want %h", k, o, e); end
    end
    tests++; if (proto_err != 0) begin failed++; $display("FAIL strobe_while_busy: got %0d want 0", proto_err); end
    obs_q.delete(); gap_q.delete();
  endtask

  initial begin
    bus.rx_byte_valid = 1'b0;
    bus.rx_byte_data  = 8'h00;
    test_reset();
    test_led_write();
    test_read();
    test_case_hex();
    test_error();
    test_timeout();
    test_overrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got no completion want finish before 500us");
    $fatal(1, "watchdog expired");
  end

endmodule
